sdram_responder: RTL
====================

SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 Parameter MEM_AW, default 14, SHALL set the internal storage word-address width (2^MEM_AW x 16 bits).
REQ-002 Ports SHALL be, clock and reset first:
  clk  in  1  single clock; all commands are sampled on its rising edge.
  rst_n  in  1  asynchronous active-low reset.
  sdram_a  in  13  row, column or mode address.
  sdram_ba  in  2  bank.
  sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe, sdram_cke  in  1 each  command pins.
  sdram_dqml, sdram_dqmh  in  1 each  byte masks.
  sdram_dq_in  in  16  write data.
  sdram_dq_out  out  16  read data.
  sdram_dq_oe  out  2  per-byte output enable: bit0 = low byte, bit1 = high byte.
  ready  out  1  init sequence complete.
  cas_lat  out  2  latched CAS latency.
  refresh_cnt  out  16  refresh command count.
  err  out  4  sticky protocol error flags.
REQ-003 Clocking and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.

Function
REQ-004 Commands SHALL decode from {nRAS,nCAS,nWE} only when ncs=0 and cke=1:
  111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 REFRESH, 000 MODE SET.
REQ-005 Each of the 4 banks SHALL hold an open flag and a 13-bit row register.
  ACTIVE sets the flag and latches sdram_a.
  PRECHARGE clears the flag of sdram_ba, or of all banks when a[10]=1.
REQ-006 The storage word address SHALL be the low MEM_AW bits of {ba, row, a[8:0]}.
REQ-007 WRITE SHALL store dq_in in the same cycle, per byte, where the byte's DQM=0.
  Both DQM=1: no store.
REQ-008 READ SHALL drive storage data on dq_out with dq_oe asserted for exactly one cycle.
  Timing: asserted in the cycle beginning CL rising edges after the READ edge.
  dq_oe byte bits = ~{dqmh,dqml} as sampled at the READ edge.
REQ-009 READ or WRITE with a[10]=1 SHALL close the addressed bank after the access.
REQ-010 MODE SET SHALL latch CL = a[6:4].
  Supported: CL 2 or 3, burst length a[2:0]=000, write mode a[9] either value.
REQ-011 Init FSM SHALL have four states: WAIT_PRE, WAIT_REF, WAIT_MRS, READY.
  WAIT_PRE to WAIT_REF on PRECHARGE with a[10]=1.
  WAIT_REF to WAIT_MRS after 2 REFRESH commands.
  WAIT_MRS to READY on a supported MODE SET.
  Output ready=1 only in READY.
  MODE SET issued in READY SHALL update CL without leaving READY.
REQ-012 refresh_cnt SHALL increment on every REFRESH and saturate at 16'hFFFF.
REQ-013 Back-to-back READs SHALL pipeline, one result per cycle.
  A READ whose data slot collides with a WRITE SHALL still return data; the write-data bus is input-only, so no contention exists.
REQ-014 Commands other than NOP received before READY SHALL not alter storage.

Reset
REQ-015 rst_n low SHALL clear asynchronously:
  all bank flags, FSM to WAIT_PRE, ready=0, cas_lat=2, refresh_cnt=0, err=0, dq_oe=0, dq_out=0, the read pipeline.
REQ-016 A reset mid-read SHALL cancel all pending data slots.
  Storage contents are not reset.

Configuration
REQ-017 Macro SDRAM_RESPONDER_ERRCHK_EN defined SHALL enable the sticky err flags:
  err[0] READ or WRITE to a closed bank.
  err[1] ACTIVE to an open bank.
  err[2] READ or WRITE before READY.
  err[3] unsupported MODE SET.
  The offending command is otherwise ignored.
REQ-018 Without the macro, err SHALL be tied to 0 and offending commands SHALL execute as decoded.

Structure
REQ-019 Package sdram_responder_pkg SHALL hold:
  the 3-bit command codes, the init-state enum, and the err bit indices.
REQ-020 One sub-module, sdram_responder_rdpipe, SHALL implement the CL-delayed data/oe pipeline (depth 3).

Verification
REQ-021 Init sequence: PRE(a10=1), REF, REF, MODE SET a=13'h0220 -> ready=1, cas_lat=2, refresh_cnt=2.
REQ-022 Write then read, CL=2:
  Stimulus: ACT ba=1 row=5; WRITE col=3 dq=16'hA55A dqm=00 with a10=1; ACT; READ col=3.
  Response: 16'hA55A with dq_oe=11 exactly 2 edges after READ; bank 1 closed after READ.
REQ-023 Byte masks:
  WRITE 16'h1234 dqm=10 over 16'hFFFF -> read returns 16'hFF34.
  READ with dqm=01 -> dq_oe=10.
REQ-024 CL=3 back-to-back READs of 3 columns -> three consecutive data cycles starting 3 edges after the first READ.
REQ-025 With ERRCHK_EN: READ to a closed bank -> err[0]=1, storage and dq_oe unchanged; rst_n pulse -> err=0.
REQ-026 Reset mid-read: assert rst_n low 1 cycle after READ -> dq_oe never asserts; ready=0.

Source files
------------

// File: rtl/sdram_responder_pkg.sv
// Shared definitions for the SDRAM responder model.
// Holds the command encodings, the init-sequence states, the sticky error
// bit positions and the read-pipeline slot layout.
package sdram_responder_pkg;

    // {nRAS, nCAS, nWE} command encodings
    localparam logic [2:0] CMD_NOP       = 3'b111;
    localparam logic [2:0] CMD_ACTIVE    = 3'b011;
    localparam logic [2:0] CMD_READ      = 3'b101;
    localparam logic [2:0] CMD_WRITE     = 3'b100;
    localparam logic [2:0] CMD_PRECHARGE = 3'b010;
    localparam logic [2:0] CMD_REFRESH   = 3'b001;
    localparam logic [2:0] CMD_MODE_SET  = 3'b000;

    typedef enum logic [1:0] {
        ST_WAIT_PRE = 2'd0,
        ST_WAIT_REF = 2'd1,
        ST_WAIT_MRS = 2'd2,
        ST_READY    = 2'd3
    } init_state_t;

    // Sticky error flag positions
    localparam int ERR_CLOSED_BANK = 0;
    localparam int ERR_ACT_OPEN    = 1;
    localparam int ERR_NOT_READY   = 2;
    localparam int ERR_BAD_MODE    = 3;

    localparam logic [1:0] CL_RESET        = 2'd2;
    localparam logic [1:0] INIT_REFRESHES  = 2'd2;
    localparam int         RD_PIPE_DEPTH   = 3;

    typedef struct packed {
        logic [1:0]  oe;
        logic [15:0] data;
    } rd_slot_t;

    // Only CL 2/3 with a burst length of one are modelled
    function automatic logic mode_supported(input logic [2:0] cl_field,
                                            input logic [2:0] bl_field);
        return ((cl_field == 3'd2) || (cl_field == 3'd3)) && (bl_field == 3'b000);
    endfunction

endpackage

// File: rtl/sdram_responder_rdpipe.sv
// CAS-latency delay line for read data and per-byte output enables.
// A read is dropped into the slot that reaches the output register exactly
// CL edges after the READ edge; slots shift one place toward the output per clock.
module sdram_responder_rdpipe
    import sdram_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [1:0]  cl,
    input  logic [1:0]  load_oe,
    input  logic [15:0] load_data,
    output logic [15:0] dq_out,
    output logic [1:0]  dq_oe
);

    rd_slot_t   slot_q [RD_PIPE_DEPTH];
    rd_slot_t   load_slot;
    logic [1:0] load_idx;

    // Slot k reaches the output register after k+1 edges, so a CL-edge delay
    // enters at k = CL-1; CL 0 cannot be honoured and falls back to slot 0
    always_comb begin
        load_slot.oe   = load_oe;
        load_slot.data = load_data;
        load_idx       = (cl == 2'd0) ? 2'd0 : cl - 2'd1;
    end

    // Shift toward the output each clock; reset cancels every pending read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_PIPE_DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            dq_out <= '0;
            dq_oe  <= '0;
        end else begin
            dq_out    <= slot_q[0].data;
            dq_oe     <= slot_q[0].oe;
            slot_q[0] <= slot_q[1];
            slot_q[1] <= slot_q[2];
            slot_q[2] <= '0;
            if (load) begin
                slot_q[load_idx] <= load_slot;
            end
        end
    end

endmodule

// File: rtl/sdram_responder.sv
// Behavioural single-data-rate SDRAM device for controller testing.
// Decodes commands, tracks per-bank open rows, stores data in a 2^MEM_AW x 16
// array, returns reads after the latched CAS latency and runs the power-up
// init sequence (precharge-all, two refreshes, mode set).
// Build option: define SDRAM_RESPONDER_ERRCHK_EN to enable sticky protocol
// error flags; offending commands are then dropped instead of executed.
//
// Init FSM states:
//   state        | meaning
//   ST_WAIT_PRE  | after reset, waiting for PRECHARGE with a[10]=1
//   ST_WAIT_REF  | counting the two required REFRESH commands
//   ST_WAIT_MRS  | waiting for a supported MODE SET
//   ST_READY     | init done, ready=1, MODE SET only updates CL
module sdram_responder
    import sdram_responder_pkg::*;
#(
    parameter int MEM_AW = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] sdram_a,
    input  logic [1:0]  sdram_ba,
    input  logic        sdram_ncs,
    input  logic        sdram_nras,
    input  logic        sdram_ncas,
    input  logic        sdram_nwe,
    input  logic        sdram_cke,
    input  logic        sdram_dqml,
    input  logic        sdram_dqmh,
    input  logic [15:0] sdram_dq_in,
    output logic [15:0] sdram_dq_out,
    output logic [1:0]  sdram_dq_oe,
    output logic        ready,
    output logic [1:0]  cas_lat,
    output logic [15:0] refresh_cnt,
    output logic [3:0]  err
);

    logic              cmd_valid;
    logic [2:0]        cmd_code;
    logic              is_act, is_rd, is_wr, is_pre, is_ref, is_mrs;
    logic              mode_ok;

    logic [3:0]        bank_open_q;
    logic [12:0]       bank_row_q [4];
    logic              bank_is_open;
    logic [MEM_AW-1:0] mem_addr;
    logic [15:0]       mem [2**MEM_AW];
    logic [15:0]       rd_data;

    logic              bad_closed, bad_act, bad_notready, bad_mode;
    logic              do_act, do_rd, do_wr, do_mrs, wr_en;

    init_state_t       state_q, state_d;
    logic [1:0]        ref_left_q;

    // Command decode; deselected or clock-disabled cycles are treated as NOP
    always_comb begin
        cmd_valid = !sdram_ncs && sdram_cke;
        cmd_code  = {sdram_nras, sdram_ncas, sdram_nwe};
        is_act    = cmd_valid && (cmd_code == CMD_ACTIVE);
        is_rd     = cmd_valid && (cmd_code == CMD_READ);
        is_wr     = cmd_valid && (cmd_code == CMD_WRITE);
        is_pre    = cmd_valid && (cmd_code == CMD_PRECHARGE);
        is_ref    = cmd_valid && (cmd_code == CMD_REFRESH);
        is_mrs    = cmd_valid && (cmd_code == CMD_MODE_SET);
        mode_ok   = mode_supported(sdram_a[6:4], sdram_a[2:0]);
    end

    // Word address uses the row latched by the bank's last ACTIVE
    always_comb begin
        bank_is_open = bank_open_q[sdram_ba];
        mem_addr     = MEM_AW'({sdram_ba, bank_row_q[sdram_ba], sdram_a[8:0]});
        rd_data      = mem[mem_addr];
    end

    // Protocol violation detection; all zero when checking is compiled out
    always_comb begin
`ifdef SDRAM_RESPONDER_ERRCHK_EN
        bad_closed   = (is_rd || is_wr) && !bank_is_open;
        bad_act      = is_act && bank_is_open;
        bad_notready = (is_rd || is_wr) && !ready;
        bad_mode     = is_mrs && !mode_ok;
`else
        bad_closed   = 1'b0;
        bad_act      = 1'b0;
        bad_notready = 1'b0;
        bad_mode     = 1'b0;
`endif
    end

    // Accepted commands; writes never touch storage before init completes
    always_comb begin
        do_act = is_act && !bad_act;
        do_rd  = is_rd && !bad_closed && !bad_notready;
        do_wr  = is_wr && !bad_closed && !bad_notready;
        do_mrs = is_mrs && !bad_mode;
        wr_en  = do_wr && ready;
    end

    // Bank open flags and row registers, including auto-precharge on a[10]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_open_q <= '0;
            for (int i = 0; i < 4; i++) begin
                bank_row_q[i] <= '0;
            end
        end else begin
            if (do_act) begin
                bank_open_q[sdram_ba] <= 1'b1;
                bank_row_q[sdram_ba]  <= sdram_a;
            end
            if (is_pre) begin
                if (sdram_a[10]) begin
                    bank_open_q <= '0;
                end else begin
                    bank_open_q[sdram_ba] <= 1'b0;
                end
            end
            if ((do_rd || do_wr) && sdram_a[10]) begin
                bank_open_q[sdram_ba] <= 1'b0;
            end
        end
    end

    // Byte-masked storage write; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (!sdram_dqml) begin
                mem[mem_addr][7:0] <= sdram_dq_in[7:0];
            end
            if (!sdram_dqmh) begin
                mem[mem_addr][15:8] <= sdram_dq_in[15:8];
            end
        end
    end

    // Init FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_PRE;
        end else begin
            state_q <= state_d;
        end
    end

    // Init FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT_PRE: if (is_pre && sdram_a[10])            state_d = ST_WAIT_REF;
            ST_WAIT_REF: if (is_ref && (ref_left_q == 2'd1))   state_d = ST_WAIT_MRS;
            ST_WAIT_MRS: if (is_mrs && mode_ok)                state_d = ST_READY;
            ST_READY:                                          state_d = ST_READY;
            default:                                           state_d = ST_WAIT_PRE;
        endcase
    end

    // Init FSM outputs
    always_comb begin
        ready = (state_q == ST_READY);
    end

    // Down-counter of refreshes still owed during WAIT_REF
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_left_q <= INIT_REFRESHES;
        end else if (state_q != ST_WAIT_REF) begin
            ref_left_q <= INIT_REFRESHES;
        end else if (is_ref && (ref_left_q != 2'd0)) begin
            ref_left_q <= ref_left_q - 2'd1;
        end
    end

    // CAS latency register and saturating refresh counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cas_lat     <= CL_RESET;
            refresh_cnt <= '0;
        end else begin
            if (do_mrs) begin
                cas_lat <= sdram_a[5:4];
            end
            if (is_ref && (refresh_cnt != 16'hFFFF)) begin
                refresh_cnt <= refresh_cnt + 16'd1;
            end
        end
    end

`ifdef SDRAM_RESPONDER_ERRCHK_EN
    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= '0;
        end else begin
            if (bad_closed)   err[ERR_CLOSED_BANK] <= 1'b1;
            if (bad_act)      err[ERR_ACT_OPEN]    <= 1'b1;
            if (bad_notready) err[ERR_NOT_READY]   <= 1'b1;
            if (bad_mode)     err[ERR_BAD_MODE]    <= 1'b1;
        end
    end
`else
    assign err = '0;
`endif

    sdram_responder_rdpipe u_rdpipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (do_rd),
        .cl        (cas_lat),
        .load_oe   (~{sdram_dqmh, sdram_dqml}),
        .load_data (rd_data),
        .dq_out    (sdram_dq_out),
        .dq_oe     (sdram_dq_oe)
    );

endmodule
